// File: rtl/tc_pkg.sv
// Shared definitions for the tile-compute psum path: FSM encodings and the
// index-width helper also used by the psum cache.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    GAP_WAIT = 2'd2,
    DRAIN    = 2'd3
  } tc_state_t;

  // Bits needed to index n entries; never less than one bit.
  function automatic int tc_idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tc_sparse_emit_1d_if.sv
// Dense-row input handshake plus the sparse write / readback bus toward the
// psum cache.
interface tc_sparse_emit_1d_if #(
  parameter int N       = 16,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DW_POS-1:0]      in_row;
  logic [N*DW_DATA-1:0]   in_data;
  logic                   in_last;
  logic [DW_POS-1:0]      row;
  logic [DW_POS-1:0]      col;
  logic [DW_DATA-1:0]     data;
  logic                   input_en;
  logic                   out_en;
  logic                   done;
  logic                   err;

  modport master (
    output in_valid, in_row, in_data, in_last,
    input  in_ready, row, col, data, input_en, out_en, done, err
  );

  modport slave (
    input  in_valid, in_row, in_data, in_last,
    output in_ready, row, col, data, input_en, out_en, done, err
  );
endinterface

// File: rtl/tc_lsb_pick.sv
// Lowest-set-bit priority encoder over an N-bit mask.
module tc_lsb_pick #(
  parameter int N      = 16,
  parameter int DW_POS = 4
) (
  input  logic [N-1:0]      mask,
  output logic [DW_POS-1:0] index,
  output logic              any
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = DW_POS'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_sparse_emit_1d.sv
// Turns dense result rows into sparse (row, col, data) cache writes and, after
// the tile's last row, sweeps out_en across every row of the cache.
module tc_sparse_emit_1d #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4,
  parameter int GAP     = 2
) (
  input logic               clk,
  input logic               rst,
  tc_sparse_emit_1d_if.slave bus
);
  import tc_pkg::*;

  localparam int CW = DW_POS + 1;
  localparam int GW = tc_idx_width(GAP);
  localparam logic [CW-1:0] M_LIM    = CW'(M);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  tc_state_t            state;
  logic [N-1:0]         mask_q;
  logic [N*DW_DATA-1:0] data_q;
  logic [DW_POS-1:0]    row_q;
  logic                 last_q;
  logic [GW-1:0]        gap_cnt;
  logic [CW-1:0]        drain_cnt;

  logic [DW_POS-1:0]    row_r;
  logic [DW_POS-1:0]    col_r;
  logic [DW_DATA-1:0]   data_r;
  logic                 input_en_r;
  logic                 out_en_r;
  logic                 done_r;
  logic                 err_r;

  logic [N-1:0]         in_mask;
  logic                 row_bad;
  logic [DW_POS-1:0]    pick_idx;
  logic                 pick_any;
  logic [DW_DATA-1:0]   pick_data;

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < N; i++) begin
      in_mask[i] = |bus.in_data[i*DW_DATA +: DW_DATA];
    end
  end

  assign row_bad = {1'b0, bus.in_row} >= M_LIM;

  tc_lsb_pick #(
    .N      (N),
    .DW_POS (DW_POS)
  ) u_pick (
    .mask  (mask_q),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Element mux keyed on the picked column; avoids a variable part-select.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == DW_POS'(i)) pick_data = data_q[i*DW_DATA +: DW_DATA];
    end
  end

  // The last GAP_WAIT edge already drives row 0, so the quiet gap between the
  // final write and the first readback is exactly GAP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= '0;
      data_q     <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
      gap_cnt    <= '0;
      drain_cnt  <= '0;
      row_r      <= '0;
      col_r      <= '0;
      data_r     <= '0;
      input_en_r <= 1'b0;
      out_en_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          input_en_r <= 1'b0;
          out_en_r   <= 1'b0;
          done_r     <= 1'b0;
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            row_q  <= bus.in_row;
            last_q <= bus.in_last;
            if (row_bad) begin
              mask_q <= '0;
              err_r  <= 1'b1;
            end else begin
              mask_q <= in_mask;
            end
            state <= SCAN;
          end
        end
        SCAN: begin
          if (pick_any) begin
            input_en_r <= 1'b1;
            row_r      <= row_q;
            col_r      <= pick_idx;
            data_r     <= pick_data;
            mask_q     <= mask_q & ~(N'(1) << pick_idx);
          end else begin
            input_en_r <= 1'b0;
            gap_cnt    <= '0;
            drain_cnt  <= '0;
            state      <= last_q ? GAP_WAIT : IDLE;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            out_en_r  <= 1'b1;
            row_r     <= '0;
            drain_cnt <= CW'(1);
            state     <= DRAIN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == M_LIM) begin
            out_en_r  <= 1'b0;
            done_r    <= 1'b1;
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            out_en_r  <= 1'b1;
            row_r     <= drain_cnt[DW_POS-1:0];
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.row      = row_r;
  assign bus.col      = col_r;
  assign bus.data     = data_r;
  assign bus.input_en = input_en_r;
  assign bus.out_en   = out_en_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule
